// File: rtl/uvma_obi_memory_slv_pkg.sv
// Shared types and constants for the OBI memory slave with response buffer.
// rsp_t is sized for the widest legal configuration (64-bit data, 16-bit id)
// so that one packed type serves every parametrisation; unused upper bits
// are simply tied to zero by the producer.
// The localparams describe the default 32-bit / depth-4 configuration, and
// word_lsb() derives the byte-offset width for any legal DATA_WIDTH.
package uvma_obi_memory_slv_pkg;

    localparam int RSP_DATA_MAX = 64;
    localparam int RSP_ID_MAX   = 16;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_MAX_OUTSTANDING = 4;

    localparam int BE_WIDTH  = DEF_DATA_WIDTH / 8;
    localparam int WORD_LSB  = $clog2(BE_WIDTH);
    localparam int PTR_WIDTH = $clog2(DEF_MAX_OUTSTANDING);

    typedef struct packed {
        logic [RSP_DATA_MAX-1:0] rdata;
        logic                    err;
        logic [RSP_ID_MAX-1:0]   rid;
    } rsp_t;

    function automatic int word_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/uvma_obi_memory_rsp_fifo.sv
// Synchronous in-order FIFO of rsp_t entries.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset (pointers/count only)
//   push, din         write an entry (ignored when full)
//   pop               discard the head entry (ignored when empty)
//   full, empty       occupancy flags derived from the registered count
//   count             number of stored entries
//   head              oldest entry; meaningless while empty
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module uvma_obi_memory_rsp_fifo
    import uvma_obi_memory_slv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  rsp_t             din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output rsp_t             head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_t             store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = store[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries data only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok)
            store[wr_ptr] <= din;
    end

endmodule

// File: rtl/uvma_obi_memory_slv_rsp_buf.sv
// OBI memory slave backed by a word-addressed array, with an in-order
// response buffer of MAX_OUTSTANDING entries.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   req, gnt, gntpar                A-channel handshake (gntpar = ~gnt)
//   addr, we, be, wdata, aid        A-channel payload
//   rvalid, rvalidpar, rready       R-channel handshake (rvalidpar = ~rvalid)
//   rdata, err, rid, exokay         R-channel payload; exokay tied 0
// Requests are granted while the buffer has room; the response is formed
// at the acceptance edge and appears on R one cycle after the grant.
// Legal widths: DATA_WIDTH 32 or 64, ID_WIDTH up to 16, MEM_DEPTH >= 2,
// ADDR_WIDTH wider than the word index plus byte offset.
module uvma_obi_memory_slv_rsp_buf #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MEM_DEPTH       = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req,
    output logic                    gnt,
    output logic                    gntpar,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [ID_WIDTH-1:0]     aid,
    output logic                    rvalid,
    output logic                    rvalidpar,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic [ID_WIDTH-1:0]     rid,
    output logic                    exokay
);

    import uvma_obi_memory_slv_pkg::*;

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int IDX_LSB = word_lsb(DATA_WIDTH);
    localparam int MEM_AW  = $clog2(MEM_DEPTH);
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic              accept;
    logic              oob;
    logic [MEM_AW-1:0] idx;
    logic [DATA_WIDTH-1:0] rd_word;
    rsp_t              push_rsp;
    rsp_t              head_rsp;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              unused_bits;

    // Any set bit above the index field addresses past MEM_DEPTH.
    assign idx     = addr[IDX_LSB +: MEM_AW];
    assign oob     = |addr[ADDR_WIDTH-1:IDX_LSB+MEM_AW];
    assign rd_word = mem[idx];

    // No pop bypass: grant depends only on the registered occupancy.
    assign gnt    = reset_n && !full;
    assign gntpar = ~gnt;
    assign accept = req && gnt;

    always_comb begin
        push_rsp                       = '0;
        push_rsp.err                   = oob;
        push_rsp.rid[ID_WIDTH-1:0]     = aid;
        push_rsp.rdata[DATA_WIDTH-1:0] = (we || oob) ? '0 : rd_word;
    end

    always_ff @(posedge clk) begin
        if (accept && we && !oob) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be[i])
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    uvma_obi_memory_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept),
        .din     (push_rsp),
        .pop     (rready),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .head    (head_rsp)
    );

    // Payload is forced to zero whenever nothing is pending, so the
    // uninitialised buffer storage is never visible on the bus.
    assign rvalid    = !empty;
    assign rvalidpar = ~rvalid;
    assign rdata     = empty ? '0 : head_rsp.rdata[DATA_WIDTH-1:0];
    assign err       = empty ? 1'b0 : head_rsp.err;
    assign rid       = empty ? '0 : head_rsp.rid[ID_WIDTH-1:0];
    assign exokay    = 1'b0;

    // Byte offset bits, the oversized struct fields and the count are
    // intentionally not consumed.
    assign unused_bits = ^{addr[IDX_LSB-1:0], head_rsp, count};

endmodule

// File: tb/tb_uvma_obi_memory_slv_rsp_buf.sv
module tb_uvma_obi_memory_slv_rsp_buf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        gnt;
    logic        gntpar;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic        rvalid;
    logic        rvalidpar;
    logic        rready;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
    logic        exokay;

    int total = 0;
    int bad   = 0;

    uvma_obi_memory_slv_rsp_buf #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .ID_WIDTH        (4),
        .MAX_OUTSTANDING (4),
        .MEM_DEPTH       (256)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .gntpar    (gntpar),
        .addr      (addr),
        .we        (we),
        .be        (be),
        .wdata     (wdata),
        .aid       (aid),
        .rvalid    (rvalid),
        .rvalidpar (rvalidpar),
        .rready    (rready),
        .rdata     (rdata),
        .err       (err),
        .rid       (rid),
        .exokay    (exokay)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with rready=1 and nothing pending.
    // Issues one request, checks grant, one-cycle response latency and pop.
    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [3:0] id,
                       input logic [31:0] exp_data, input logic exp_err);
        req = 1'b1; we = w; addr = a; wdata = d; be = b; aid = id;
        @(negedge clk);
        chk({tag, "_gnt"}, 64'(gnt), 64'd1);
        chk({tag, "_rvalid_pre"}, 64'(rvalid), 64'd0);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        chk({tag, "_rid"}, 64'(rid), 64'(id));
        chk({tag, "_rdata"}, 64'(rdata), 64'(exp_data));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        @(posedge clk); #1;
        chk({tag, "_popped"}, 64'(rvalid), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0;
        be = '0; wdata = '0; aid = '0; rready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_gntpar", 64'(gntpar), 64'd1);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rvalidpar", 64'(rvalidpar), 64'd1);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        chk("rst_exokay", 64'(exokay), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("rel_gnt", 64'(gnt), 64'd1);
        chk("rel_gntpar", 64'(gntpar), 64'd0);
        rready = 1'b1;

        // write then read
        txn("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd3, 32'h0, 1'b0);
        txn("rd10", 1'b0, 32'h10, 32'h0, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0);
        txn("rd13", 1'b0, 32'h13, 32'h0, 4'h0, 4'd6, 32'hDEADBEEF, 1'b0);

        // byte enables
        txn("wr20z", 1'b1, 32'h20, 32'h0, 4'hF, 4'd1, 32'h0, 1'b0);
        txn("wr20b", 1'b1, 32'h20, 32'h11223344, 4'b0101, 4'd2, 32'h0, 1'b0);
        txn("rd20", 1'b0, 32'h20, 32'h0, 4'hF, 4'd4, 32'h00220044, 1'b0);
        txn("wr20n", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 4'd7, 32'h0, 1'b0);
        txn("rd20n", 1'b0, 32'h20, 32'h0, 4'h0, 4'd8, 32'h00220044, 1'b0);

        // out of range
        txn("wr0", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 4'd9, 32'h0, 1'b0);
        txn("oob_wr", 1'b1, 32'h400, 32'h12345678, 4'hF, 4'd10, 32'h0, 1'b1);
        txn("oob_rd", 1'b0, 32'h400, 32'h0, 4'hF, 4'd11, 32'h0, 1'b1);
        txn("oob_hi", 1'b0, 32'h8000_0000, 32'h0, 4'hF, 4'd12, 32'h0, 1'b1);
        txn("rd0", 1'b0, 32'h0, 32'h0, 4'hF, 4'd13, 32'hCAFEF00D, 1'b0);

        // backpressure: fill four entries, two more requests held off
        rready = 1'b0;
        req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            aid = 4'(i);
            @(negedge clk);
            chk("bp_fill_gnt", 64'(gnt), 64'd1);
            @(posedge clk); #1;
        end
        aid = 4'd4;
        @(negedge clk);
        chk("bp_full_gnt", 64'(gnt), 64'd0);
        chk("bp_full_gntpar", 64'(gntpar), 64'd1);
        chk("bp_head_rid", 64'(rid), 64'd0);
        chk("bp_head_rdata", 64'(rdata), 64'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_hold_gnt", 64'(gnt), 64'd0);
        chk("bp_hold_rvalid", 64'(rvalid), 64'd1);
        chk("bp_hold_rid", 64'(rid), 64'd0);
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        chk("bp_nobypass_gnt", 64'(gnt), 64'd0);
        chk("bp_pop0_rid", 64'(rid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_regrant", 64'(gnt), 64'd1);
        chk("bp_pop1_rid", 64'(rid), 64'd1);
        @(posedge clk); #1;
        aid = 4'd5;
        @(negedge clk);
        chk("bp_pushpop_gnt", 64'(gnt), 64'd1);
        chk("bp_pop2_rid", 64'(rid), 64'd2);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("bp_pop3_rid", 64'(rid), 64'd3);
        @(posedge clk);
        @(negedge clk);
        chk("bp_pop4_rid", 64'(rid), 64'd4);
        @(posedge clk);
        @(negedge clk);
        chk("bp_pop5_rid", 64'(rid), 64'd5);
        chk("bp_pop5_rdata", 64'(rdata), 64'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        chk("bp_drained", 64'(rvalid), 64'd0);

        // reset mid-operation with three responses pending
        @(posedge clk); #1;
        rready = 1'b0;
        req = 1'b1; we = 1'b0; addr = 32'h10;
        for (int i = 7; i < 10; i++) begin
            aid = 4'(i);
            @(posedge clk); #1;
        end
        req = 1'b0;
        @(negedge clk);
        chk("mr_pending_rid", 64'(rid), 64'd7);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_rvalid_drop", 64'(rvalid), 64'd0);
        chk("mr_rvalidpar", 64'(rvalidpar), 64'd1);
        chk("mr_gnt", 64'(gnt), 64'd0);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        chk("mr_after_rvalid", 64'(rvalid), 64'd0);
        chk("mr_after_gnt", 64'(gnt), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("mr_stale_rvalid", 64'(rvalid), 64'd0);
        @(posedge clk); #1;
        txn("mr_mem_kept", 1'b0, 32'h10, 32'h0, 4'hF, 4'd2, 32'hDEADBEEF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
